// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment readback path: display codes,
// segment patterns (MSB=a .. LSB=g) and the scan FSM states.
package seg7_pkg;

    typedef logic [4:0] cod_t;
    typedef logic [6:0] pat_t;

    typedef enum logic [1:0] {
        ESPERA,
        CONTANDO,
        CAPTURADO
    } estado_t;

    localparam cod_t COD_BLANCO   = 5'd16;
    localparam cod_t COD_GUION    = 5'd17;
    localparam cod_t COD_INVALIDO = 5'd18;

    localparam pat_t PAT_0      = 7'b1111110;
    localparam pat_t PAT_1      = 7'b0110000;
    localparam pat_t PAT_2      = 7'b1101101;
    localparam pat_t PAT_3      = 7'b1111001;
    localparam pat_t PAT_4      = 7'b0110011;
    localparam pat_t PAT_5      = 7'b1011011;
    localparam pat_t PAT_6      = 7'b1011111;
    localparam pat_t PAT_7      = 7'b1110000;
    localparam pat_t PAT_8      = 7'b1111111;
    localparam pat_t PAT_9      = 7'b1111011;
    localparam pat_t PAT_A      = 7'b1110111;
    localparam pat_t PAT_B      = 7'b0011111;
    localparam pat_t PAT_C      = 7'b1001110;
    localparam pat_t PAT_D      = 7'b0111101;
    localparam pat_t PAT_E      = 7'b1001111;
    localparam pat_t PAT_F      = 7'b1000111;
    localparam pat_t PAT_BLANCO = 7'b0000000;
    localparam pat_t PAT_GUION  = 7'b0000001;

endpackage

// File: rtl/seg7_patron_decod.sv
// Combinational inverse of the hex-to-7-segment encoder: pattern -> display code,
// flagging any pattern the encoder can never produce.
module seg7_patron_decod
    import seg7_pkg::*;
(
    input  pat_t i_patron,
    output logic o_invalido,
    output cod_t o_codigo
);

    always_comb begin
        o_invalido = 1'b0;
        o_codigo   = COD_INVALIDO;
        case (i_patron)
            PAT_0:      o_codigo = 5'd0;
            PAT_1:      o_codigo = 5'd1;
            PAT_2:      o_codigo = 5'd2;
            PAT_3:      o_codigo = 5'd3;
            PAT_4:      o_codigo = 5'd4;
            PAT_5:      o_codigo = 5'd5;
            PAT_6:      o_codigo = 5'd6;
            PAT_7:      o_codigo = 5'd7;
            PAT_8:      o_codigo = 5'd8;
            PAT_9:      o_codigo = 5'd9;
            PAT_A:      o_codigo = 5'd10;
            PAT_B:      o_codigo = 5'd11;
            PAT_C:      o_codigo = 5'd12;
            PAT_D:      o_codigo = 5'd13;
            PAT_E:      o_codigo = 5'd14;
            PAT_F:      o_codigo = 5'd15;
            PAT_BLANCO: o_codigo = COD_BLANCO;
            PAT_GUION:  o_codigo = COD_GUION;
            default:    o_invalido = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, debounces each digit, decodes it and hands
// off complete frames over valid/ready. SEG7_ACTIVO_BAJO_EN selects active-low inputs.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter  int N_DIG   = 4,
    parameter  int ESTABLE = 3,
    localparam int CNT_W   = $clog2(ESTABLE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           segmentos,
    input  logic [N_DIG-1:0]     anodos,
    input  logic                 listo,
    output logic [5*N_DIG-1:0]   codigos,
    output logic                 valido,
    output logic                 dig_nuevo,
    output logic                 err_cod,
    output logic                 desborde
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    pat_t             r_seg_m, r_seg_s;
    logic [N_DIG-1:0] r_an_m, r_an_s;
    pat_t             w_seg;
    logic [N_DIG-1:0] w_an, w_an_m1;

    estado_t          r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic [N_DIG-1:0] r_an_lat;
    pat_t             r_pat;

    logic             w_onehot, w_cambio, w_nuevo, w_cap, w_inv, w_lleno, w_acepta;
    logic [IDX_W-1:0] w_idx;
    pat_t             w_dec_in;
    cod_t             w_cod;

    cod_t [N_DIG-1:0] r_dig, w_dig_nxt, r_frame;
    logic [N_DIG-1:0] r_mask, w_mask_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_m <= '0;
            r_seg_s <= '0;
            r_an_m  <= '0;
            r_an_s  <= '0;
        end else begin
            r_seg_m <= segmentos;
            r_seg_s <= r_seg_m;
            r_an_m  <= anodos;
            r_an_s  <= r_an_m;
        end
    end

`ifdef SEG7_ACTIVO_BAJO_EN
    assign w_seg = ~r_seg_s;
    assign w_an  = ~r_an_s;
`else
    assign w_seg = r_seg_s;
    assign w_an  = r_an_s;
`endif

    assign w_an_m1  = w_an - N_DIG'(1);
    assign w_onehot = (w_an != '0) && ((w_an & w_an_m1) == '0);
    assign w_cambio = (w_an != r_an_lat) || (w_seg != r_pat);
    assign w_nuevo  = (r_estado == ESPERA) || w_cambio;

    // A fresh run counts as one stable cycle, so with ESTABLE==1 the capture
    // lands on the same edge the value is first seen and must decode it directly.
    assign w_cap = w_onehot && (w_nuevo ? (ESTABLE == 1)
                                        : ((r_estado == CONTANDO) && (int'(r_cnt) + 1 == ESTABLE)));
    assign w_dec_in = (ESTABLE == 1) ? w_seg : r_pat;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_DIG; i++)
            if (w_an[i]) w_idx = IDX_W'(i);
    end

    seg7_patron_decod u_decod (
        .i_patron   (w_dec_in),
        .o_invalido (w_inv),
        .o_codigo   (w_cod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= ESPERA;
            r_cnt    <= '0;
            r_an_lat <= '0;
            r_pat    <= '0;
        end else if (w_nuevo) begin
            if (w_onehot) begin
                r_estado <= w_cap ? CAPTURADO : CONTANDO;
                r_cnt    <= CNT_W'(1);
                r_an_lat <= w_an;
                r_pat    <= w_seg;
            end else begin
                r_estado <= ESPERA;
                r_cnt    <= '0;
            end
        end else if (r_estado == CONTANDO) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cap) r_estado <= CAPTURADO;
        end
    end

    always_comb begin
        w_dig_nxt  = r_dig;
        w_mask_nxt = r_mask;
        if (w_cap) begin
            w_dig_nxt[w_idx]  = w_cod;
            w_mask_nxt[w_idx] = 1'b1;
        end
    end

    assign w_lleno  = w_cap && (&w_mask_nxt);
    assign w_acepta = valido && listo;
    assign codigos  = r_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig     <= {N_DIG{COD_BLANCO}};
            r_frame   <= {N_DIG{COD_BLANCO}};
            r_mask    <= '0;
            valido    <= 1'b0;
            dig_nuevo <= 1'b0;
            err_cod   <= 1'b0;
            desborde  <= 1'b0;
        end else begin
            dig_nuevo <= w_cap;
            err_cod   <= w_cap && w_inv;
            r_dig     <= w_dig_nxt;
            if (w_lleno) begin
                // A frame completing while the previous one is still unaccepted is lost.
                r_mask <= '0;
                if (!valido || w_acepta) begin
                    r_frame <= w_dig_nxt;
                    valido  <= 1'b1;
                end else begin
                    desborde <= 1'b1;
                end
            end else begin
                r_mask <= w_mask_nxt;
                if (w_acepta) valido <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random bursts, checked every
// cycle against a run-length reference model. Honours SEG7_ACTIVO_BAJO_EN.
module tb_seg7_scan_decoder;

    localparam int N_DIG   = 4;
    localparam int ESTABLE = 3;
`ifdef SEG7_ACTIVO_BAJO_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst, listo;
    logic [6:0]          segmentos;
    logic [N_DIG-1:0]    anodos;
    logic [5*N_DIG-1:0]  codigos;
    logic                valido, dig_nuevo, err_cod, desborde;

    int n_chk = 0, n_err = 0, n_pulso = 0, n_errp = 0;

    seg7_scan_decoder #(.N_DIG(N_DIG), .ESTABLE(ESTABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .segmentos (segmentos),
        .anodos    (anodos),
        .listo     (listo),
        .codigos   (codigos),
        .valido    (valido),
        .dig_nuevo (dig_nuevo),
        .err_cod   (err_cod),
        .desborde  (desborde)
    );

    always #5 clk = ~clk;

    // index = display code
    logic [6:0] tbl [18] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
                             7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
                             7'b1000111, 7'b0000000, 7'b0000001};

    // logical (active-high) view of what the bench is driving
    logic [N_DIG-1:0] cur_an;
    logic [6:0]       cur_seg;

    // reference model state
    logic [N_DIG-1:0] m1_an, m2_an, p_an, m_mask;
    logic [6:0]       m1_seg, m2_seg, p_seg;
    int               run;
    logic [4:0]       m_dig [N_DIG];
    logic [4:0]       m_frame [N_DIG];
    logic             e_val, e_new, e_err, e_desb;

    function automatic logic [4:0] dec(input logic [6:0] p);
        for (int i = 0; i < 18; i++)
            if (tbl[i] == p) return 5'(i);
        return 5'd18;
    endfunction

    function automatic logic [5*N_DIG-1:0] pack_frame();
        logic [5*N_DIG-1:0] v;
        for (int i = 0; i < N_DIG; i++) v[5*i +: 5] = m_frame[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic put(input logic [N_DIG-1:0] an, input logic [6:0] seg);
        cur_an  = an;
        cur_seg = seg;
        anodos    = INV ? ~an  : an;
        segmentos = INV ? ~seg : seg;
    endtask

    // One clock edge of the reference: two-edge delay, then a digit is captured
    // when a one-hot (anode, pattern) pair has been seen for exactly ESTABLE edges.
    task automatic model();
        logic [N_DIG-1:0] s_an;
        logic [6:0]       s_seg;
        logic [4:0]       c;
        logic             acc;
        if (rst) begin
            m1_an = INV ? '1 : '0;  m2_an = m1_an;  p_an = m1_an;
            m1_seg = INV ? '1 : '0; m2_seg = m1_seg; p_seg = m1_seg;
            run = 0; m_mask = '0;
            for (int i = 0; i < N_DIG; i++) begin m_dig[i] = 5'd16; m_frame[i] = 5'd16; end
            e_val = 0; e_new = 0; e_err = 0; e_desb = 0;
            return;
        end
        s_an = m2_an; s_seg = m2_seg;
        m2_an = m1_an; m2_seg = m1_seg;
        m1_an = cur_an; m1_seg = cur_seg;
        if (s_an == p_an && s_seg == p_seg) begin
            if (run < 1000) run++;
        end else begin
            run = 1;
        end
        p_an = s_an; p_seg = s_seg;
        e_new = (run == ESTABLE) && ($countones(s_an) == 1);
        c = dec(s_seg);
        e_err = e_new && (c == 5'd18);
        acc = e_val && listo;
        if (e_new)
            for (int i = 0; i < N_DIG; i++)
                if (s_an[i]) begin m_dig[i] = c; m_mask[i] = 1'b1; end
        if (e_new && (&m_mask)) begin
            m_mask = '0;
            if (!e_val || acc) begin
                for (int i = 0; i < N_DIG; i++) m_frame[i] = m_dig[i];
                e_val = 1;
            end else begin
                e_desb = 1;
            end
        end else if (acc) begin
            e_val = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        @(negedge clk);
        chk("valido",    32'(valido),    32'(e_val));
        chk("dig_nuevo", 32'(dig_nuevo), 32'(e_new));
        chk("err_cod",   32'(err_cod),   32'(e_err));
        chk("desborde",  32'(desborde),  32'(e_desb));
        chk("codigos",   32'(codigos),   32'(pack_frame()));
        if (dig_nuevo) n_pulso++;
        if (err_cod)   n_errp++;
    endtask

    task automatic hold(input logic [N_DIG-1:0] an, input logic [6:0] seg, input int n);
        put(an, seg);
        repeat (n) tick();
    endtask

    initial begin
        logic [N_DIG-1:0] an;
        logic [6:0]       seg;
        int               r, len;
        logic [19:0]      exp_frame;

        rst = 1'b1; listo = 1'b0;
        put('0, '0);
        tick(); tick();
        chk("rst_codigos", 32'(codigos), 32'({4{5'd16}}));
        chk("rst_valido", 32'(valido), 32'd0);
        rst = 1'b0;

        // single digit
        n_pulso = 0; n_errp = 0;
        hold(4'b0001, 7'b1111001, 5);
        hold('0, '0, 4);
        chk("t2_pulsos", 32'(n_pulso), 32'd1);
        chk("t2_err", 32'(n_errp), 32'd0);

        // full frame 1,2,A,dash
        hold(4'b0001, tbl[1], 4);
        hold(4'b0010, tbl[2], 4);
        hold(4'b0100, tbl[10], 4);
        hold(4'b1000, tbl[17], 4);
        hold('0, '0, 4);
        exp_frame = {5'd17, 5'd10, 5'd2, 5'd1};
        chk("t3_valido", 32'(valido), 32'd1);
        chk("t3_codigos", 32'(codigos), 32'(exp_frame));
        listo = 1'b1; tick(); listo = 1'b0; tick();
        chk("t3_aceptado", 32'(valido), 32'd0);

        // glitch inside window and multi-hot anodes
        n_pulso = 0;
        hold(4'b0010, tbl[5], 2);
        hold(4'b0010, tbl[6], 1);
        hold(4'b0010, tbl[5], 2);
        hold('0, '0, 3);
        hold(4'b0011, tbl[8], 6);
        hold('0, '0, 3);
        chk("t4_pulsos", 32'(n_pulso), 32'd0);
        hold(4'b0010, tbl[5], 3);
        hold('0, '0, 3);
        chk("t4_limpio", 32'(n_pulso), 32'd1);

        // invalid pattern, then a frame followed by a dropped frame
        n_errp = 0;
        hold(4'b0001, 7'b1010101, 4);
        hold(4'b0010, tbl[4], 4);
        hold(4'b0100, tbl[5], 4);
        hold(4'b1000, tbl[6], 4);
        hold('0, '0, 3);
        chk("t5_err", 32'(n_errp), 32'd1);
        exp_frame = {5'd6, 5'd5, 5'd4, 5'd18};
        chk("t5_codigos", 32'(codigos), 32'(exp_frame));
        hold(4'b0001, tbl[7], 4);
        hold(4'b0010, tbl[8], 4);
        hold(4'b0100, tbl[9], 4);
        hold(4'b1000, tbl[11], 4);
        hold('0, '0, 3);
        chk("t5_desborde", 32'(desborde), 32'd1);
        chk("t5_retiene", 32'(codigos), 32'(exp_frame));

        // random bursts
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            r   = $urandom_range(0, 99);
            an  = N_DIG'(1) << $urandom_range(0, N_DIG - 1);
            seg = (r < 85) ? tbl[$urandom_range(0, 17)] : 7'($urandom);
            if (r >= 95) an = N_DIG'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            len = $urandom_range(1, 6);
            put(an, seg);
            for (int j = 0; j < len; j++) begin
                listo = ($urandom_range(0, 3) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
